// File: rtl/two_bit_counter_monitor_if.sv
// Bus between an upstream two-bit counter and its monitor.
// master: observation source (drives the sampled count/carry, sees results)
// slave : the monitor (consumes count/carry, drives reconstruction/status)
//   in_cnt    [1:0]   sampled count value
//   in_z              sampled carry flag
//   x_rec             reconstructed count-enable (1 = step, 0 = hold)
//   rec_valid         x_rec valid for this cycle
//   err               one-cycle pulse on an illegal transition
//   locked            monitor is tracking
//   wrap_cnt  [CNT_W] legal 3->0 steps, modulo 2^CNT_W
//   err_cnt   [CNT_W] illegal transitions, saturating
interface two_bit_counter_monitor_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       in_cnt;
  logic             in_z;
  logic             x_rec;
  logic             rec_valid;
  logic             err;
  logic             locked;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_cnt, in_z,
    input  x_rec, rec_valid, err, locked, wrap_cnt, err_cnt
  );

  modport slave (
    input  in_cnt, in_z,
    output x_rec, rec_valid, err, locked, wrap_cnt, err_cnt
  );
endinterface

// File: rtl/two_bit_counter_monitor.sv
// Watches the {count, carry} output of a two-bit up-counter, reconstructs its
// count-enable and flags transitions the counter cannot legally produce.
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   io_mon : slave side of two_bit_counter_monitor_if (see interface header)
// States: IDLE captures the first sample, TRACK reports x_rec, FAULT waits for
// RESYNC_LEN consecutive legal pairs before trusting the counter again.
module two_bit_counter_monitor #(
  parameter int ERR_LIMIT  = 3,
  parameter int RESYNC_LEN = 4,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  two_bit_counter_monitor_if.slave  io_mon
);

  // Counters only need to reach LIMIT-1; the LIMIT-th event changes state.
  localparam int EW = (ERR_LIMIT  > 1) ? $clog2(ERR_LIMIT)  : 1;
  localparam int RW = (RESYNC_LEN > 1) ? $clog2(RESYNC_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_prev;
  logic [EW-1:0]    r_cons_err;
  logic [RW-1:0]    r_run;
  logic             r_x_rec;
  logic             r_rec_valid;
  logic             r_err;
  logic             r_locked;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [1:0] w_prev_inc;
  logic       w_hold;
  logic       w_step;
  logic       w_legal;
  logic       w_eval;
  logic       w_bad;
  logic       w_wrap;

  // Carry is only legal together with the 3->0 step; carry on a hold is illegal.
  assign w_prev_inc = r_prev + 2'd1;
  assign w_hold     = (io_mon.in_cnt == r_prev) && !io_mon.in_z;
  assign w_step     = (io_mon.in_cnt == w_prev_inc) && (io_mon.in_z == (r_prev == 2'd3));
  assign w_legal    = w_hold || w_step;
  assign w_eval     = (r_state == S_TRACK) || (r_state == S_FAULT);
  assign w_bad      = w_eval && !w_legal;
  assign w_wrap     = w_eval && w_step && (r_prev == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_cons_err  <= '0;
      r_run       <= '0;
      r_x_rec     <= 1'b0;
      r_rec_valid <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_wrap_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_prev      <= io_mon.in_cnt;
      r_rec_valid <= 1'b0;
      r_err       <= w_bad;

      if (w_bad && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
      if (w_wrap)
        r_wrap_cnt <= r_wrap_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_state    <= S_TRACK;
          r_locked   <= 1'b1;
          r_cons_err <= '0;
          r_run      <= '0;
        end
        S_TRACK: begin
          if (w_legal) begin
            r_rec_valid <= 1'b1;
            r_x_rec     <= w_step;
            r_cons_err  <= '0;
          end else if (r_cons_err == EW'(ERR_LIMIT - 1)) begin
            r_state    <= S_FAULT;
            r_locked   <= 1'b0;
            r_cons_err <= '0;
            r_run      <= '0;
          end else begin
            r_cons_err <= r_cons_err + 1'b1;
          end
        end
        S_FAULT: begin
          if (w_legal) begin
            // x_rec keeps following legal pairs; rec_valid stays low until
            // the pair after relock.
            r_x_rec <= w_step;
            if (r_run == RW'(RESYNC_LEN - 1)) begin
              r_state    <= S_TRACK;
              r_locked   <= 1'b1;
              r_run      <= '0;
              r_cons_err <= '0;
            end else begin
              r_run <= r_run + 1'b1;
            end
          end else begin
            r_run <= '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign io_mon.x_rec     = r_x_rec;
  assign io_mon.rec_valid = r_rec_valid;
  assign io_mon.err       = r_err;
  assign io_mon.locked    = r_locked;
  assign io_mon.wrap_cnt  = r_wrap_cnt;
  assign io_mon.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_two_bit_counter_monitor.sv
module tb_two_bit_counter_monitor;

  localparam int ERR_LIMIT  = 3;
  localparam int RESYNC_LEN = 4;
  localparam int CNT_W      = 8;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   miscompares = 0;

  two_bit_counter_monitor_if #(.CNT_W(CNT_W)) bus();

  two_bit_counter_monitor #(
    .ERR_LIMIT(ERR_LIMIT), .RESYNC_LEN(RESYNC_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .io_mon(bus)
  );

  always #5 clk = ~clk;

  // Reference model: the counter rules with integers and a locked flag.
  bit m_started, m_locked, m_x, m_rv, m_err;
  int m_prev, m_cons, m_run, m_wrap, m_errs;

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_x = 0; m_rv = 0; m_err = 0;
    m_prev = 0; m_cons = 0; m_run = 0; m_wrap = 0; m_errs = 0;
  endtask

  task automatic model_step(input int c, input bit z);
    bit is_step, legal;
    if (!m_started) begin
      m_started = 1; m_locked = 1; m_rv = 0; m_err = 0; m_cons = 0; m_run = 0;
    end else begin
      is_step = (c == (m_prev + 1) % 4) && (z == (m_prev == 3));
      legal   = is_step || (c == m_prev && !z);
      m_err = !legal;
      m_rv  = 0;
      if (legal) begin
        m_x = is_step;
        if (is_step && m_prev == 3) m_wrap = (m_wrap + 1) % (CMAX + 1);
        if (m_locked) begin
          m_rv = 1; m_cons = 0;
        end else begin
          m_run++;
          if (m_run == RESYNC_LEN) begin m_locked = 1; m_run = 0; m_cons = 0; end
        end
      end else begin
        if (m_errs < CMAX) m_errs++;
        if (m_locked) begin
          m_cons++;
          if (m_cons == ERR_LIMIT) begin m_locked = 0; m_run = 0; end
        end else m_run = 0;
      end
    end
    m_prev = c;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit x, input bit rv, input bit e,
                         input bit lk, input int w, input int ec);
    chk({tag, ".x_rec"},     32'(bus.x_rec),     32'(x));
    chk({tag, ".rec_valid"}, 32'(bus.rec_valid), 32'(rv));
    chk({tag, ".err"},       32'(bus.err),       32'(e));
    chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    chk({tag, ".wrap_cnt"},  32'(bus.wrap_cnt),  32'(w));
    chk({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(ec));
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, m_x, m_rv, m_err, m_locked, m_wrap, m_errs);
  endtask

  // Drive one sample between edges, clock it, then sample just after the edge.
  task automatic apply(input int c, input bit z);
    @(negedge clk);
    bus.in_cnt = 2'(c);
    bus.in_z   = z;
    @(posedge clk);
    #1;
    model_step(c, z);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_out("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int c; bit z; bit x; bit rv; bit e; bit lk; int w; int ec;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // count up with one wrap, hold at 2, then a 1->3 jump and recovery
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 0, 1, 0, 0};
    tbl[2]  = '{2, 0, 1, 1, 0, 1, 0, 0};
    tbl[3]  = '{3, 0, 1, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 1, 1, 0, 1, 1, 0};
    tbl[6]  = '{2, 0, 1, 1, 0, 1, 1, 0};
    for (int i = 7; i < 12; i++) tbl[i] = '{2, 0, 0, 1, 0, 1, 1, 0};
    tbl[12] = '{3, 0, 1, 1, 0, 1, 1, 0};
    tbl[13] = '{0, 1, 1, 1, 0, 1, 2, 0};
    tbl[14] = '{1, 0, 1, 1, 0, 1, 2, 0};
    tbl[15] = '{3, 0, 1, 0, 1, 1, 2, 1};
    tbl[16] = '{0, 1, 1, 1, 0, 1, 3, 1};

    reset = 1'b1;
    bus.in_cnt = 2'd0;
    bus.in_z   = 1'b0;
    model_reset();
    #3 chk_out("por", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].c, tbl[i].z);
      chk_out($sformatf("tbl%0d", i), tbl[i].x, tbl[i].rv, tbl[i].e,
              tbl[i].lk, tbl[i].w, tbl[i].ec);
    end

    // Reset mid-count: the first post-reset edge only captures, even though
    // a 0->2 pair would be illegal.
    apply(1, 0);
    do_reset();
    apply(2, 0);
    chk_out("post_rst_capture", 0, 0, 0, 1, 0, 0);
    apply(3, 0);
    chk_out("post_rst_first", 1, 1, 0, 1, 0, 0);

    // Three carry-without-step pairs drop lock; four legal steps relock.
    do_reset();
    apply(0, 0);
    for (int i = 1; i <= 3; i++) begin
      apply(0, 1);
      chk_out($sformatf("fault_err%0d", i), 0, 0, 1, (i < 3), 0, i);
    end
    for (int i = 1; i <= 4; i++) begin
      apply(i % 4, (i % 4) == 0);
      chk_out($sformatf("resync%0d", i), 1, 0, 0, (i == 4), (i == 4), 3);
    end
    apply(1, 0);
    chk_out("resync_valid", 1, 1, 0, 1, 1, 3);

    // err_cnt saturation
    do_reset();
    apply(0, 0);
    for (int i = 0; i < 300; i++) apply(0, 1);
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'(CMAX));
    chk("err_still_pulses", 32'(bus.err), 32'd1);

    // wrap_cnt rollover over 257 wraps
    do_reset();
    apply(0, 0);
    for (int i = 1; i <= 257 * 4; i++) begin
      apply(i % 4, (i % 4) == 0);
      if (i == 256 * 4) chk("wrap_256", 32'(bus.wrap_cnt), 32'd0);
    end
    chk("wrap_257", 32'(bus.wrap_cnt), 32'd1);
    chk("wrap_locked", 32'(bus.locked), 32'd1);

    // Random traffic against the model, alternating calm and noisy phases.
    do_reset();
    begin
      int p;
      int c;
      bit z;
      int r;
      int noisy;
      p = 0;
      for (int i = 0; i < 600; i++) begin
        noisy = ((i / 40) % 2) ? 70 : 12;
        r = $urandom_range(0, 99);
        if (r < noisy) begin
          c = $urandom_range(0, 3);
          z = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 1) == 0) begin
          c = p; z = 1'b0;
        end else begin
          c = (p + 1) % 4; z = (p == 3);
        end
        apply(c, z);
        chk_model($sformatf("rnd%0d", i));
        p = c;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
